fp_acc: RTL and testbench

- Downstream consumer of the fixed-point multiplier; accumulates a stream of signed Q(IN_INT).(IN_FRAC) products into a wide accumulator.
- Each accumulation window is closed by a beat count or by in_last. The sum is then rounded and saturated to Q(OUT_INT).(OUT_FRAC) and presented on a valid/ready output.
- Forms the dot-product / FIR tail of the multiply pipeline.

---
 rtl/fp_pkg.sv | 19 +
 rtl/fp_round_sat.sv | 40 ++++
 rtl/fp_acc.sv | 112 +++++++++++
 tb/tb_fp_acc.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and fixed-point helpers for the accumulate/requantise path.
package fp_pkg;

    typedef enum logic [1:0] {S_ACC, S_RND, S_OUT} state_t;

    function automatic int fx_width(input int int_bits, input int frac_bits);
        return int_bits + frac_bits;
    endfunction

    // Signed two's-complement range of a w-bit word, w < 64.
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/fp_round_sat.sv
// Combinational requantiser: round half toward +inf, arithmetic shift right,
// saturate to OUT_W bits and flag the clamp.
module fp_round_sat
    import fp_pkg::*;
#(
    parameter int IN_W  = 22,
    parameter int SHIFT = 4,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    sat
);
    localparam int                   HS   = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [IN_W:0] ONE  = 1;
    localparam logic signed [IN_W:0] HALF = (SHIFT > 0) ? (ONE <<< HS) : '0;
    localparam longint               OMAX = sat_max(OUT_W);
    localparam longint               OMIN = sat_min(OUT_W);

    logic signed [IN_W:0] r;
    logic signed [IN_W:0] q;
    longint               qx;

    // One guard bit keeps the rounding add from wrapping at the top of range.
    always_comb begin
        r    = {din[IN_W-1], din} + HALF;
        q    = r >>> SHIFT;
        qx   = longint'(q);
        sat  = 1'b0;
        dout = OUT_W'(qx);
        if (qx > OMAX) begin
            dout = OUT_W'(OMAX);
            sat  = 1'b1;
        end else if (qx < OMIN) begin
            dout = OUT_W'(OMIN);
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/fp_acc.sv
// Windowed saturating accumulator for the multiply pipeline; each window is
// rounded/saturated into a single valid/ready result.
module fp_acc
    import fp_pkg::*;
#(
    parameter int IN_INT   = 6,
    parameter int IN_FRAC  = 12,
    parameter int ACC_INT  = 10,
    parameter int ACC_FRAC = 12,
    parameter int OUT_INT  = 8,
    parameter int OUT_FRAC = 8,
    parameter int LEN      = 16,
    parameter int CNT_W    = $clog2(LEN + 1)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic signed [IN_INT+IN_FRAC-1:0]    in_data,
    input  logic                                in_last,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [OUT_INT+OUT_FRAC-1:0]  out_data,
    output logic                                out_ovf,
    output logic [CNT_W-1:0]                    out_count
);
    localparam int ACC_W = fx_width(ACC_INT, ACC_FRAC);
    localparam int OUT_W = fx_width(OUT_INT, OUT_FRAC);
    localparam int FS    = ACC_FRAC - IN_FRAC;
    localparam int RS    = ACC_FRAC - OUT_FRAC;

    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));
    localparam logic [CNT_W-1:0]        LEN_C   = CNT_W'(LEN);

    state_t                   state, nxt;
    logic signed [ACC_W-1:0]  acc, ext, acc_nxt;
    logic signed [ACC_W:0]    sum;
    logic                     add_ovf;
    logic [CNT_W-1:0]         cnt;
    logic                     sticky, take, win_end;
    logic signed [OUT_W-1:0]  rnd;
    logic                     rnd_sat;

    assign in_ready = (state == S_ACC);
    assign take     = in_valid && in_ready;
    assign win_end  = in_last || (cnt + 1'b1 == LEN_C);

    // Align the beat to the accumulator binary point, then add with clamp.
    always_comb begin
        ext     = ACC_W'(in_data) <<< FS;
        sum     = {acc[ACC_W-1], acc} + {ext[ACC_W-1], ext};
        add_ovf = sum[ACC_W] ^ sum[ACC_W-1];
        acc_nxt = sum[ACC_W-1:0];
        if (add_ovf) acc_nxt = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end

    fp_round_sat #(.IN_W(ACC_W), .SHIFT(RS), .OUT_W(OUT_W)) u_round_sat (
        .din  (acc),
        .dout (rnd),
        .sat  (rnd_sat)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= S_ACC;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_ACC:   if (take && win_end) nxt = S_RND;
            S_RND:   nxt = S_OUT;
            S_OUT:   if (out_ready) nxt = S_ACC;
            default: nxt = S_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc       <= '0;
            cnt       <= '0;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_count <= '0;
        end else begin
            case (state)
                S_ACC: if (take) begin
                    acc    <= acc_nxt;
                    sticky <= sticky | add_ovf;
                    cnt    <= cnt + 1'b1;
                end
                S_RND: begin
                    out_data  <= rnd;
                    out_ovf   <= sticky | rnd_sat;
                    out_count <= cnt;
                    out_valid <= 1'b1;
                end
                S_OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    acc       <= '0;
                    cnt       <= '0;
                    sticky    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_acc.sv
// Directed + randomized bench for fp_acc against an integer-arithmetic model.
module tb_fp_acc;
    localparam int IN_W  = 18;
    localparam int OUT_W = 16;
    localparam int CNT_W = 5;
    localparam int LEN   = 16;
    localparam int FS    = 0;   // ACC_FRAC - IN_FRAC
    localparam int RS    = 4;   // ACC_FRAC - OUT_FRAC
    localparam longint ACC_HI = 2097151;   // 22-bit signed range
    localparam longint ACC_LO = -2097152;
    localparam longint OUT_HI = 32767;
    localparam longint OUT_LO = -32768;

    typedef logic signed [63:0] v64;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid, in_ready, in_last;
    logic signed [IN_W-1:0]  in_data;
    logic                    out_valid, out_ready, out_ovf;
    logic signed [OUT_W-1:0] out_data;
    logic [CNT_W-1:0]        out_count;

    fp_acc dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .out_count(out_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    longint       m_sum;
    bit           m_sticky;
    int           m_cnt;
    logic [17:0]  beats [16];

    task automatic chk(input string tag, input v64 obs, input v64 exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic m_beat(input logic [17:0] d);
        m_sum = m_sum + longint'(signed'(d)) * (longint'(1) << FS);
        if (m_sum > ACC_HI) begin m_sum = ACC_HI; m_sticky = 1'b1; end
        else if (m_sum < ACC_LO) begin m_sum = ACC_LO; m_sticky = 1'b1; end
        m_cnt++;
    endtask

    // Round half up, floor-divide, clamp to the output range.
    task automatic m_result(output longint q, output bit ovf);
        longint d, r;
        d   = longint'(1) << RS;
        r   = m_sum + d / 2;
        q   = r / d;
        if ((r % d != 0) && (r < 0)) q = q - 1;
        ovf = m_sticky;
        if (q > OUT_HI) begin q = OUT_HI; ovf = 1'b1; end
        else if (q < OUT_LO) begin q = OUT_LO; ovf = 1'b1; end
    endtask

    task automatic run_window(input string tag, input int n, input bit last);
        longint q;
        bit     ovf;
        m_sum = 0; m_sticky = 1'b0; m_cnt = 0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = beats[i];
            in_last  = last && (i == n - 1);
            @(posedge clk); #1;
            m_beat(beats[i]);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        m_result(q, ovf);
        chk({tag, ".rnd_valid"}, v64'(out_valid), 0);
        chk({tag, ".rnd_ready"}, v64'(in_ready), 0);
        @(posedge clk); #1;
        chk({tag, ".valid"}, v64'(out_valid), 1);
        chk({tag, ".data"},  v64'(out_data), q);
        chk({tag, ".ovf"},   v64'(out_ovf), v64'(ovf));
        chk({tag, ".count"}, v64'(out_count), m_cnt);
        if (out_ready) begin
            @(posedge clk); #1;
            chk({tag, ".drop"},  v64'(out_valid), 0);
            chk({tag, ".ready"}, v64'(in_ready), 1);
        end
    endtask

    task automatic fill(input logic [17:0] v);
        for (int i = 0; i < 16; i++) beats[i] = v;
    endtask

    initial begin
        logic signed [15:0] hd;
        logic               ho;
        logic [CNT_W-1:0]   hc;
        reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.in_ready", v64'(in_ready), 1);
        chk("rst.out_valid", v64'(out_valid), 0);
        chk("rst.out_data", v64'(out_data), 0);
        chk("rst.out_ovf", v64'(out_ovf), 0);
        chk("rst.out_count", v64'(out_count), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        fill(18'd2048);           run_window("half16", 16, 1'b0);
        chk("half16.value", v64'(out_data), 16'sh0800);
        beats[0] = 18'd8;         run_window("rnd_up", 1, 1'b1);
        beats[0] = -18'sd8;       run_window("rnd_neg", 1, 1'b1);
        fill(18'h1FFFF);          run_window("satpos", 16, 1'b0);
        fill(18'd0);              run_window("sticky_clr", 16, 1'b0);
        fill(-18'sd4096);         run_window("neg16", 16, 1'b0);
        chk("neg16.value", v64'(out_data), -16'sh1000);
        fill(18'h20000);          run_window("satneg", 16, 1'b0);

        // Backpressure: result must hold and no beat may be taken.
        out_ready = 1'b0;
        fill(18'd1000);           run_window("hold", 5, 1'b1);
        hd = out_data; ho = out_ovf; hc = out_count;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = IN_W'($urandom);
            @(posedge clk); #1;
            chk("hold.valid", v64'(out_valid), 1);
            chk("hold.in_ready", v64'(in_ready), 0);
            chk("hold.data", v64'(out_data), v64'(hd));
            chk("hold.ovf", v64'(out_ovf), v64'(ho));
            chk("hold.count", v64'(out_count), v64'(hc));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold.release_valid", v64'(out_valid), 0);
        chk("hold.release_ready", v64'(in_ready), 1);
        fill(18'd4096);           run_window("after_hold", 3, 1'b1);

        // Mid-window reset discards the partial sum.
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = 18'd4096;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("midrst.in_ready", v64'(in_ready), 1);
        fill(18'd4096);           run_window("midrst", 16, 1'b0);
        chk("midrst.value", v64'(out_data), 16'sh1000);

        // Reset while a result is pending drops it.
        out_ready = 1'b0;
        fill(18'd300);            run_window("pend", 2, 1'b1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        out_ready = 1'b1;
        chk("pend.dropped", v64'(out_valid), 0);
        chk("pend.data_clr", v64'(out_data), 0);

        for (int w = 0; w < 8; w++) begin
            int  n;
            bit  lst;
            n   = $urandom_range(1, 16);
            lst = (n < 16) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < 16; i++)
                beats[i] = (w % 2 == 0) ? 18'($urandom) : 18'(int'($urandom_range(0, 8191)) - 4096);
            run_window($sformatf("rand%0d", w), n, lst);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
